// File: rtl/fifo_controller_prog_pkg.sv
// Shared types and helpers for the programmable-threshold FIFO controller.
// Status flags travel together as one packed struct so the reset value is defined in one place.
package fifo_pkg;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    localparam fifo_status_t STATUS_RESET = '{
        empty:        1'b1,
        full:         1'b0,
        almost_empty: 1'b1,
        almost_full:  1'b0,
        overflow:     1'b0,
        underflow:    1'b0
    };

    // Count and thresholds need one extra bit so that a completely full FIFO (DEPTH) fits.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_controller_prog_if.sv
// Producer/consumer strobes, thresholds and status outputs of the FIFO controller.
// The master side drives requests and thresholds; the slave side is the controller.
interface fifo_controller_prog_if #(
    parameter int ADDR_WIDTH = 4
);
    import fifo_pkg::*;

    localparam int CNT_WIDTH = cnt_width(ADDR_WIDTH);

    logic                  write_i;
    logic                  read_i;
    logic [CNT_WIDTH-1:0]  af_thresh_i;
    logic [CNT_WIDTH-1:0]  ae_thresh_i;
    logic                  err_clear_i;

    logic                  write_en_o;
    logic                  read_en_o;
    logic [ADDR_WIDTH-1:0] write_address_o;
    logic [ADDR_WIDTH-1:0] read_address_o;
    logic [CNT_WIDTH-1:0]  count_o;
    logic                  empty_o;
    logic                  full_o;
    logic                  almost_empty_o;
    logic                  almost_full_o;
    logic                  overflow_o;
    logic                  underflow_o;

    modport master (
        output write_i, read_i, af_thresh_i, ae_thresh_i, err_clear_i,
        input  write_en_o, read_en_o, write_address_o, read_address_o, count_o,
        input  empty_o, full_o, almost_empty_o, almost_full_o, overflow_o, underflow_o
    );

    modport slave (
        input  write_i, read_i, af_thresh_i, ae_thresh_i, err_clear_i,
        output write_en_o, read_en_o, write_address_o, read_address_o, count_o,
        output empty_o, full_o, almost_empty_o, almost_full_o, overflow_o, underflow_o
    );

endinterface

// File: rtl/fifo_controller_prog_ptr.sv
// Wrapping FIFO pointer: ADDR_WIDTH address bits plus one wrap bit, advancing by one when enabled.
// The next value is exported so the owner can derive the fill level from both pointers' next state.
module fifo_ptr #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH:0]   ptr_next
);

    logic [ADDR_WIDTH:0] ptr;

    assign ptr_next = ptr + (ADDR_WIDTH+1)'(en);
    assign addr     = ptr[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/fifo_controller_prog.sv
// FIFO pointer/status controller for an external 2**ADDR_WIDTH-entry storage array, with
// runtime-programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_controller_prog #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    fifo_controller_prog_if.slave  bus
);
    import fifo_pkg::*;

    localparam int CNT_WIDTH = cnt_width(ADDR_WIDTH);
    localparam logic [CNT_WIDTH-1:0] DEPTH = CNT_WIDTH'(2 ** ADDR_WIDTH);

    logic [1:0]            rst_sync;
    logic                  rst_n;
    logic                  write_en;
    logic                  read_en;
    logic [ADDR_WIDTH:0]   wr_next;
    logic [ADDR_WIDTH:0]   rd_next;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [CNT_WIDTH-1:0]  count;
    logic [CNT_WIDTH-1:0]  count_next;
    logic                  overflow_set;
    logic                  underflow_set;
    fifo_status_t          status;

    // Assertion reaches every register at once; release is delayed two edges to avoid metastability.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // A read while full frees the slot the concurrent write lands in, so both are accepted.
    assign read_en  = bus.read_i & ~status.empty & rst_n;
    assign write_en = bus.write_i & (~status.full | bus.read_i) & rst_n;

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk      (clk_i),
        .rst_n    (rst_n),
        .en       (write_en),
        .addr     (wr_addr),
        .ptr_next (wr_next)
    );

    fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk      (clk_i),
        .rst_n    (rst_n),
        .en       (read_en),
        .addr     (rd_addr),
        .ptr_next (rd_next)
    );

    assign count_next    = wr_next - rd_next;
    assign overflow_set  = bus.write_i & status.full & ~bus.read_i;
    assign underflow_set = bus.read_i & status.empty;

    // Flags are computed from the next level so they line up with count in the following cycle.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            status <= STATUS_RESET;
        end else begin
            count               <= count_next;
            status.empty        <= (count_next == '0);
            status.full         <= (count_next == DEPTH);
            status.almost_empty <= (count_next <= bus.ae_thresh_i);
            status.almost_full  <= (count_next >= bus.af_thresh_i);
            status.overflow     <= overflow_set  | (status.overflow  & ~bus.err_clear_i);
            status.underflow    <= underflow_set | (status.underflow & ~bus.err_clear_i);
        end
    end

    assign bus.write_en_o      = write_en;
    assign bus.read_en_o       = read_en;
    assign bus.write_address_o = wr_addr;
    assign bus.read_address_o  = rd_addr;
    assign bus.count_o         = count;
    assign bus.empty_o         = status.empty;
    assign bus.full_o          = status.full;
    assign bus.almost_empty_o  = status.almost_empty;
    assign bus.almost_full_o   = status.almost_full;
    assign bus.overflow_o      = status.overflow;
    assign bus.underflow_o     = status.underflow;

endmodule

// File: tb/tb_fifo_controller_prog.sv
// Self-checking bench for fifo_controller_prog: directed scenarios plus random traffic,
// all compared against a behavioural model of fill level, slot indices and error flags.
module tb_fifo_controller_prog;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk;
    logic reset_n;

    fifo_controller_prog_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_controller_prog #(.ADDR_WIDTH(AW)) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model state
    int m_count, m_wr, m_rd;
    bit m_ovf, m_unf, m_af, m_ae;
    bit exp_we, exp_re;
    int exp_wa, exp_ra;
    bit obs_we, obs_re;
    int obs_wa, obs_ra;

    task automatic model_reset();
        m_count = 0; m_wr = 0; m_rd = 0;
        m_ovf = 0; m_unf = 0; m_af = 0; m_ae = 1;
    endtask

    // One clock of traffic: drive at the falling edge, sample enables before the rising edge,
    // then advance the model by the rules of the FIFO.
    task automatic cycle(input bit w, input bit r, input bit clr);
        @(negedge clk);
        bus.write_i = w; bus.read_i = r; bus.err_clear_i = clr;
        #1;
        exp_re = r && (m_count > 0);
        exp_we = w && ((m_count < DEPTH) || r);
        exp_wa = m_wr; exp_ra = m_rd;
        obs_we = bus.write_en_o; obs_re = bus.read_en_o;
        obs_wa = int'(bus.write_address_o); obs_ra = int'(bus.read_address_o);
        @(posedge clk);
        #1;
        m_ovf = (w && m_count == DEPTH && !r) || (m_ovf && !clr);
        m_unf = (r && m_count == 0) || (m_unf && !clr);
        if (exp_we) m_wr = (m_wr + 1) % DEPTH;
        if (exp_re) m_rd = (m_rd + 1) % DEPTH;
        m_count = m_count + int'(exp_we) - int'(exp_re);
        m_af = m_count >= int'(bus.af_thresh_i);
        m_ae = m_count <= int'(bus.ae_thresh_i);
        bus.write_i = 0; bus.read_i = 0; bus.err_clear_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) cycle(0, 0, 0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.write_i = 0; bus.read_i = 0; bus.err_clear_i = 0;
        bus.af_thresh_i = 5'd14; bus.ae_thresh_i = 5'd2;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (bus.count_o !== 5'd0) begin n_err++; $display("[TB] FAIL reset.count got %0d exp 0", bus.count_o); end
        n_vec++; if (bus.empty_o !== 1'b1) begin n_err++; $display("[TB] FAIL reset.empty got %b exp 1", bus.empty_o); end
        n_vec++; if (bus.almost_empty_o !== 1'b1) begin n_err++; $display("[TB] FAIL reset.almost_empty got %b exp 1", bus.almost_empty_o); end
        n_vec++; if (bus.full_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset.full got %b exp 0", bus.full_o); end
        n_vec++; if (bus.almost_full_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset.almost_full got %b exp 0", bus.almost_full_o); end
        n_vec++; if (bus.write_address_o !== 4'd0 || bus.read_address_o !== 4'd0) begin n_err++; $display("[TB] FAIL reset.addr got w%0d r%0d exp 0 0", bus.write_address_o, bus.read_address_o); end
        n_vec++; if (bus.overflow_o !== 1'b0 || bus.underflow_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset.errors got o%b u%b exp 0 0", bus.overflow_o, bus.underflow_o); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) cycle(0, 0, 0);
        n_vec++; if (bus.count_o !== 5'd0 || bus.empty_o !== 1'b1 || bus.almost_empty_o !== 1'b1) begin n_err++; $display("[TB] FAIL idle.state got c%0d e%b ae%b exp 0 1 1", bus.count_o, bus.empty_o, bus.almost_empty_o); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH + 1; i++) begin
            cycle(1, 0, 0);
            n_vec++; if (obs_we !== exp_we) begin n_err++; $display("[TB] FAIL fill.write_en[%0d] got %b exp %b", i, obs_we, exp_we); end
            n_vec++; if (obs_wa !== exp_wa) begin n_err++; $display("[TB] FAIL fill.write_addr[%0d] got %0d exp %0d", i, obs_wa, exp_wa); end
            n_vec++; if (int'(bus.count_o) !== m_count) begin n_err++; $display("[TB] FAIL fill.count[%0d] got %0d exp %0d", i, bus.count_o, m_count); end
            n_vec++; if (bus.almost_full_o !== m_af || bus.full_o !== (m_count == DEPTH)) begin n_err++; $display("[TB] FAIL fill.flags[%0d] got af%b f%b exp af%b f%b", i, bus.almost_full_o, bus.full_o, m_af, m_count == DEPTH); end
            n_vec++; if (bus.overflow_o !== m_ovf) begin n_err++; $display("[TB] FAIL fill.overflow[%0d] got %b exp %b", i, bus.overflow_o, m_ovf); end
        end
        n_vec++; if (bus.count_o !== 5'd16 || bus.overflow_o !== 1'b1 || bus.write_address_o !== 4'd0) begin n_err++; $display("[TB] FAIL fill.end got c%0d o%b wa%0d exp 16 1 0", bus.count_o, bus.overflow_o, bus.write_address_o); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < DEPTH + 1; i++) begin
            cycle(0, 1, 0);
            n_vec++; if (obs_re !== exp_re) begin n_err++; $display("[TB] FAIL drain.read_en[%0d] got %b exp %b", i, obs_re, exp_re); end
            n_vec++; if (obs_ra !== exp_ra) begin n_err++; $display("[TB] FAIL drain.read_addr[%0d] got %0d exp %0d", i, obs_ra, exp_ra); end
            n_vec++; if (int'(bus.count_o) !== m_count) begin n_err++; $display("[TB] FAIL drain.count[%0d] got %0d exp %0d", i, bus.count_o, m_count); end
            n_vec++; if (bus.almost_empty_o !== m_ae || bus.empty_o !== (m_count == 0)) begin n_err++; $display("[TB] FAIL drain.flags[%0d] got ae%b e%b exp ae%b e%b", i, bus.almost_empty_o, bus.empty_o, m_ae, m_count == 0); end
            n_vec++; if (bus.underflow_o !== m_unf) begin n_err++; $display("[TB] FAIL drain.underflow[%0d] got %b exp %b", i, bus.underflow_o, m_unf); end
        end
        n_vec++; if (bus.underflow_o !== 1'b1 || bus.overflow_o !== 1'b1) begin n_err++; $display("[TB] FAIL drain.errors got o%b u%b exp 1 1", bus.overflow_o, bus.underflow_o); end
        cycle(0, 0, 1);
        n_vec++; if (bus.underflow_o !== 1'b0 || bus.overflow_o !== 1'b0) begin n_err++; $display("[TB] FAIL clear.errors got o%b u%b exp 0 0", bus.overflow_o, bus.underflow_o); end
    endtask

    task automatic test_rw_empty();
        for (int i = 0; i < DEPTH + 1; i++) begin
            cycle(1, 1, 0);
            n_vec++; if (obs_we !== exp_we || obs_re !== exp_re) begin n_err++; $display("[TB] FAIL rwe.en[%0d] got w%b r%b exp w%b r%b", i, obs_we, obs_re, exp_we, exp_re); end
            n_vec++; if (obs_wa !== exp_wa || obs_ra !== exp_ra) begin n_err++; $display("[TB] FAIL rwe.addr[%0d] got w%0d r%0d exp w%0d r%0d", i, obs_wa, obs_ra, exp_wa, exp_ra); end
            n_vec++; if (int'(bus.count_o) !== m_count || bus.underflow_o !== m_unf) begin n_err++; $display("[TB] FAIL rwe.state[%0d] got c%0d u%b exp c%0d u%b", i, bus.count_o, bus.underflow_o, m_count, m_unf); end
        end
        n_vec++; if (bus.count_o !== 5'd1 || bus.underflow_o !== 1'b1) begin n_err++; $display("[TB] FAIL rwe.end got c%0d u%b exp 1 1", bus.count_o, bus.underflow_o); end
        cycle(0, 0, 1);
    endtask

    task automatic test_rw_full();
        for (int i = 0; i < 2 * DEPTH && m_count < DEPTH; i++) cycle(1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 0);
            n_vec++; if (obs_wa !== exp_wa || obs_ra !== exp_ra) begin n_err++; $display("[TB] FAIL rwf.addr[%0d] got w%0d r%0d exp w%0d r%0d", i, obs_wa, obs_ra, exp_wa, exp_ra); end
            n_vec++; if (bus.count_o !== 5'd16 || bus.full_o !== 1'b1 || bus.overflow_o !== 1'b0) begin n_err++; $display("[TB] FAIL rwf.state[%0d] got c%0d f%b o%b exp 16 1 0", i, bus.count_o, bus.full_o, bus.overflow_o); end
        end
    endtask

    task automatic test_thresh_and_reset();
        do_reset();
        repeat (8) cycle(1, 0, 0);
        n_vec++; if (bus.count_o !== 5'd8 || bus.almost_full_o !== 1'b0) begin n_err++; $display("[TB] FAIL thresh.before got c%0d af%b exp 8 0", bus.count_o, bus.almost_full_o); end
        bus.af_thresh_i = 5'd5;
        cycle(0, 0, 0);
        n_vec++; if (bus.almost_full_o !== 1'b1 || m_af !== 1'b1) begin n_err++; $display("[TB] FAIL thresh.after got af%b exp 1", bus.almost_full_o); end
        cycle(1, 0, 0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if (bus.count_o !== 5'd0 || bus.empty_o !== 1'b1 || bus.almost_empty_o !== 1'b1) begin n_err++; $display("[TB] FAIL midreset.level got c%0d e%b ae%b exp 0 1 1", bus.count_o, bus.empty_o, bus.almost_empty_o); end
        n_vec++; if (bus.full_o !== 1'b0 || bus.almost_full_o !== 1'b0) begin n_err++; $display("[TB] FAIL midreset.full got f%b af%b exp 0 0", bus.full_o, bus.almost_full_o); end
        n_vec++; if (bus.write_address_o !== 4'd0 || bus.read_address_o !== 4'd0) begin n_err++; $display("[TB] FAIL midreset.addr got w%0d r%0d exp 0 0", bus.write_address_o, bus.read_address_o); end
        model_reset();
        bus.af_thresh_i = 5'd14;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) cycle(0, 0, 0);
    endtask

    task automatic test_random();
        bit w, r, c;
        for (int i = 0; i < 600; i++) begin
            if (i % 30 == 0) begin
                bus.af_thresh_i = 5'($urandom_range(0, 31));
                bus.ae_thresh_i = 5'($urandom_range(0, 31));
            end
            // Alternate fill-biased and drain-biased phases to reach both boundaries
            if ((i / 60) % 2 == 0) begin
                w = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 3) != 0);
            end
            c = ($urandom_range(0, 15) == 0);
            cycle(w, r, c);
            n_vec++; if (obs_we !== exp_we || obs_re !== exp_re) begin n_err++; $display("[TB] FAIL rand.en[%0d] got w%b r%b exp w%b r%b", i, obs_we, obs_re, exp_we, exp_re); end
            n_vec++; if (obs_wa !== exp_wa || obs_ra !== exp_ra) begin n_err++; $display("[TB] FAIL rand.addr[%0d] got w%0d r%0d exp w%0d r%0d", i, obs_wa, obs_ra, exp_wa, exp_ra); end
            n_vec++; if (int'(bus.count_o) !== m_count) begin n_err++; $display("[TB] FAIL rand.count[%0d] got %0d exp %0d", i, bus.count_o, m_count); end
            n_vec++; if (bus.empty_o !== (m_count == 0) || bus.full_o !== (m_count == DEPTH)) begin n_err++; $display("[TB] FAIL rand.ef[%0d] got e%b f%b exp e%b f%b", i, bus.empty_o, bus.full_o, m_count == 0, m_count == DEPTH); end
            n_vec++; if (bus.almost_empty_o !== m_ae || bus.almost_full_o !== m_af) begin n_err++; $display("[TB] FAIL rand.almost[%0d] got ae%b af%b exp ae%b af%b", i, bus.almost_empty_o, bus.almost_full_o, m_ae, m_af); end
            n_vec++; if (bus.overflow_o !== m_ovf || bus.underflow_o !== m_unf) begin n_err++; $display("[TB] FAIL rand.err[%0d] got o%b u%b exp o%b u%b", i, bus.overflow_o, bus.underflow_o, m_ovf, m_unf); end
        end
        bus.af_thresh_i = 5'd14;
        bus.ae_thresh_i = 5'd2;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_fill();
        test_drain();
        test_rw_empty();
        test_rw_full();
        test_thresh_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
